// File: rtl/ram_1port_pkg.sv
// Shared constants and FSM encoding for the single-port RAM burst master.
package ram_1port_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 4;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_master_rd_stage.sv
// Single-entry output register for the read stream.
// Load takes priority over clear, so a handshake and a new load in the same
// cycle hand the next word straight through without a bubble.
module ram_master_rd_stage
    import ram_1port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    // Load a new word, or drop valid once the held word has been taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else if (load) begin
            rd_valid <= 1'b1;
            rd_data  <= load_data;
            rd_last  <= load_last;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_1port_master.sv
// Burst master for a single-port RAM (registered write, combinational read).
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the producer holds valid and its payload stable until that edge,
// and ready never depends combinationally on the same channel's valid.
module ram_1port_master
    import ram_1port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic              ram_enb,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_DONE  = ST_DONE;

    // Longest legal burst covers the whole RAM exactly once.
    localparam logic [LEN_W:0] LEN_MAX = (LEN_W + 1)'(2 ** ADDR_W);

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remain;
    logic              err_q;

    logic cmd_fire;
    logic len_bad;
    logic rd_load;
    logic rd_fire_last;

    assign cmd_fire     = cmd_valid && cmd_ready;
    assign len_bad      = (cmd_len == '0) || ({1'b0, cmd_len} > LEN_MAX);
    assign rd_load      = (state == S_READ) && (!rd_valid || rd_ready) && (remain != '0);
    assign rd_fire_last = rd_valid && rd_ready && rd_last;

    assign cmd_ready  = (state == S_IDLE);
    assign wr_ready   = (state == S_WRITE);
    // The RAM is only ever written from WRITE, so reads never see forced data.
    assign ram_enb    = (state == S_WRITE) && wr_valid;
    assign ram_addr   = cur_addr;
    assign ram_w_data = wr_data;
    assign done       = (state == S_DONE);
    assign err        = (state == S_DONE) && err_q;
    assign dbg_state  = state;

    // Burst sequencing: latch the command, then step address and count per beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            remain   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        cur_addr <= cmd_addr;
                        remain   <= cmd_len;
                        err_q    <= len_bad;
                        if (len_bad)        state <= S_DONE;
                        else if (cmd_write) state <= S_WRITE;
                        else                state <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        remain   <= remain - LEN_W'(1);
                        if (remain == LEN_W'(1)) state <= S_DONE;
                    end
                end
                S_READ: begin
                    if (rd_load) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        remain   <= remain - LEN_W'(1);
                    end
                    if (rd_fire_last) state <= S_DONE;
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    ram_master_rd_stage #(
        .DATA_W (DATA_W)
    ) u_rd_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (rd_load),
        .load_data (ram_r_data),
        .load_last (remain == LEN_W'(1)),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last)
    );

endmodule

// File: tb/tb_ram_1port_master.sv
// Directed bench for ram_1port_master with a behavioural 128x4 RAM attached.
module tb_ram_1port_master;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 4;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              done;
    logic              err;
    logic              ram_enb;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_w_data;
    logic [DATA_W-1:0] ram_r_data;
    logic [1:0]        dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] wbuf  [$];

    // Clock and reset
    always #5 clk = ~clk;

    // RAM model: async clear on reset, registered write, combinational read.
    logic [DATA_W-1:0] mem [128];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) mem[i] <= '0;
        end else if (ram_enb) begin
            mem[ram_addr] <= ram_w_data;
        end
    end
    assign ram_r_data = mem[ram_addr];

    ram_1port_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .done       (done),
        .err        (err),
        .ram_enb    (ram_enb),
        .ram_addr   (ram_addr),
        .ram_w_data (ram_w_data),
        .ram_r_data (ram_r_data),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command; returns 1 ns into the cycle after acceptance.
    task automatic issue_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        #1 check("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1 check("cmd_ready_busy", cmd_ready, 0);
    endtask

    // Write burst from wbuf; gap_at inserts one idle wr_valid cycle before that beat.
    task automatic write_burst(input logic [ADDR_W-1:0] a, input int len, input int gap_at);
        issue_cmd(1'b1, a, LEN_W'(len));
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                wr_valid = 1'b0;
                #1 check("wr_gap_enb", ram_enb, 0);
                check("wr_gap_ready", wr_ready, 1);
                @(negedge clk);
            end
            wr_valid = 1'b1;
            wr_data  = wbuf.pop_front();
            #1 check("wr_enb", ram_enb, 1);
            check("wr_ready", wr_ready, 1);
            check("wr_addr", ram_addr, 32'(ADDR_W'(a + ADDR_W'(i))));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1 check("wr_done", done, 1);
        check("wr_err", err, 0);
        check("wr_done_enb", ram_enb, 0);
        @(negedge clk);
        #1 check("wr_cmd_ready_back", cmd_ready, 1);
        check("wr_done_pulse", done, 0);
    endtask

    // Read burst checked against exp_q; bp applies a 1,0,0,1 rd_ready pattern.
    task automatic read_burst(input logic [ADDR_W-1:0] a, input int len, input bit bp);
        int beats = 0;
        int k     = 0;
        int cyc   = 0;
        issue_cmd(1'b0, a, LEN_W'(len));
        while (beats < len && cyc < 1000) begin
            rd_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            #1 check("rd_enb", ram_enb, 0);
            if (rd_valid) begin
                check("rd_data", rd_data, exp_q[0]);
                check("rd_last", rd_last, (beats == len - 1));
                if (rd_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        check("rd_beats", beats, len);
        if (!bp) check("rd_cycles", cyc, len + 1);
        rd_ready = 1'b0;
        #1 check("rd_done", done, 1);
        check("rd_err", err, 0);
        check("rd_valid_after", rd_valid, 0);
        @(negedge clk);
        #1 check("rd_cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic illegal_cmd(input logic [LEN_W-1:0] len);
        issue_cmd(1'b1, 7'd3, len);
        check("ill_done", done, 1);
        check("ill_err", err, 1);
        check("ill_enb", ram_enb, 0);
        check("ill_state", dbg_state, 3);
        @(negedge clk);
        #1 check("ill_cmd_ready", cmd_ready, 1);
        check("ill_err_clear", err, 0);
        check("ill_done_clear", done, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, dbg_state, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_last"}, rd_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_enb"}, ram_enb, 0);
        check({tag, "_addr"}, ram_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        // Reset state
        #2 check_reset_values("rst");
        @(negedge clk);
        rst = 1'b1;

        // Write then read back A, B, C at address 5
        wbuf = '{4'hA, 4'hB, 4'hC};
        write_burst(7'd5, 3, -1);
        exp_q = '{4'hA, 4'hB, 4'hC};
        read_burst(7'd5, 3, 1'b0);

        // Wrap across the top address, with one wr_valid gap
        wbuf = '{4'h1, 4'h2, 4'h3, 4'h4};
        write_burst(7'd126, 4, 2);
        exp_q = '{4'h3, 4'h4};
        read_burst(7'd0, 2, 1'b0);

        // Back-pressured read across the wrap
        exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        read_burst(7'd126, 4, 1'b1);

        // Illegal lengths
        illegal_cmd(8'd0);
        illegal_cmd(8'd129);

        // Reset during the second beat of a length-8 write
        issue_cmd(1'b1, 7'd0, 8'd8);
        wr_valid = 1'b1;
        wr_data  = 4'h9;
        @(negedge clk);
        wr_data = 4'h7;
        #1 rst = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        wr_valid = 1'b0;
        rst      = 1'b1;
        #1 check("midrst_released_state", dbg_state, 0);
        exp_q = '{4'h0};
        read_burst(7'd0, 1, 1'b0);

        // Full-depth write and read
        for (int i = 0; i < 128; i++) begin
            wbuf.push_back(DATA_W'(i % 16));
            exp_q.push_back(DATA_W'(i % 16));
        end
        write_burst(7'd0, 128, -1);
        read_burst(7'd0, 128, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
